// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor with a segmented carry chain, valid/ready flow control and ALU flags.
// Optional build macro ADDSUB_SATURATE_EN adds a per-op `sat` input that clamps signed overflow.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef ADDSUB_SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned SEG = WIDTH / STAGES;
  localparam int unsigned NP  = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int unsigned MSB = WIDTH - 1;

  logic             advance;
  logic             sat_in;

  // Stage-k inputs (s_*) and the partial result/carry it produces (n_*).
  logic [WIDTH-1:0] s_a [STAGES];
  logic [WIDTH-1:0] s_b [STAGES];
  logic [WIDTH-1:0] s_r [STAGES];
  logic             s_c [STAGES];
  logic             s_v [STAGES];
  logic             s_s [STAGES];
  logic [WIDTH-1:0] n_r [STAGES];
  logic             n_c [STAGES];
  logic [SEG:0]     seg_sum;

  logic [WIDTH-1:0] pa_q [NP];
  logic [WIDTH-1:0] pb_q [NP];
  logic [WIDTH-1:0] pr_q [NP];
  logic             pc_q [NP];
  logic             pv_q [NP];
  logic             ps_q [NP];

  logic [WIDTH-1:0] raw_d;
  logic [WIDTH-1:0] result_d;
  logic             ovf_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

`ifdef ADDSUB_SATURATE_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  assign advance  = !out_valid_q | out_ready;
  assign in_ready = advance;

  always_comb begin
    s_v[0] = in_valid;
    s_a[0] = a;
    s_b[0] = sub ? ~b : b;
    s_r[0] = '0;
    s_c[0] = sub;
    s_s[0] = sat_in;
    for (int unsigned k = 1; k < STAGES; k++) begin
      s_v[k] = pv_q[k-1];
      s_a[k] = pa_q[k-1];
      s_b[k] = pb_q[k-1];
      s_r[k] = pr_q[k-1];
      s_c[k] = pc_q[k-1];
      s_s[k] = ps_q[k-1];
    end

    // Each stage adds only its own SEG-bit slice; full operands ride along for the flags.
    seg_sum = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      seg_sum = {1'b0, SEG'(s_a[k] >> (k * SEG))}
              + {1'b0, SEG'(s_b[k] >> (k * SEG))}
              + {{SEG{1'b0}}, s_c[k]};
      n_c[k]  = seg_sum[SEG];
      n_r[k]  = s_r[k] | (WIDTH'(seg_sum[SEG-1:0]) << (k * SEG));
    end

    raw_d    = n_r[STAGES-1];
    ovf_d    = (s_a[STAGES-1][MSB] == s_b[STAGES-1][MSB]) & (raw_d[MSB] != s_a[STAGES-1][MSB]);
    result_d = raw_d;
    if (s_s[STAGES-1] && ovf_d) begin
      result_d = s_a[STAGES-1][MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < NP; j++) begin
        pv_q[j] <= 1'b0;
        pa_q[j] <= '0;
        pb_q[j] <= '0;
        pr_q[j] <= '0;
        pc_q[j] <= 1'b0;
        ps_q[j] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else if (advance) begin
      for (int unsigned j = 0; j + 1 < STAGES; j++) begin
        pv_q[j] <= s_v[j];
        pa_q[j] <= s_a[j];
        pb_q[j] <= s_b[j];
        pr_q[j] <= n_r[j];
        pc_q[j] <= n_c[j];
        ps_q[j] <= s_s[j];
      end
      out_valid_q <= s_v[STAGES-1];
      if (s_v[STAGES-1]) begin
        result_q <= result_d;
        carry_q  <= n_c[STAGES-1];
        ovf_q    <= ovf_d;
        zero_q   <= (result_d == '0);
        neg_q    <= result_d[MSB];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed self-checking bench for pipelined_addsub (WIDTH=32, STAGES=4): flags, latency, stalls, async reset.
// Build with ADDSUB_SATURATE_EN defined to also exercise the saturating path.
module tb_pipelined_addsub;

  localparam int unsigned W = 32;
  localparam int unsigned S = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         negative;
`ifdef ADDSUB_SATURATE_EN
  logic         sat_r;
`endif

  int errors = 0;
  int checks = 0;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
`ifdef ADDSUB_SATURATE_EN
    .sat       (sat_r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One isolated op with out_ready high; lat counts clock edges from accept to out_valid.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input logic tsat,
                        output logic [W-1:0] r, output logic [3:0] f, output int lat);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    sub       = ts;
    out_ready = 1'b1;
`ifdef ADDSUB_SATURATE_EN
    sat_r     = tsat;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    f = {carry_out, overflow, zero, negative};
    @(posedge clk); #1;
  endtask

  // Back-to-back ops; rnd=0 stalls out_ready for cycles 5..7, rnd=1 uses random operands and back-pressure.
  task automatic stream(input int n, input bit rnd);
    logic [W-1:0] q[$];
    logic [W-1:0] held;
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    logic         ts;
    logic         stalled;
    int           sent;
    int           got;
    int           cyc;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    ta = '0; tb = '0; ts = 1'b0;
    while (got < n && cyc < n * 6 + 50) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 5 && cyc < 8);
      if (sent < n) begin
        ta = rnd ? $urandom : 32'hF000_0000 + W'(sent) * 32'h1357_9BDF;
        tb = rnd ? $urandom : 32'h0FFF_FFFF * W'(sent);
        ts = rnd ? 1'($urandom_range(0, 1)) : 1'(sent & 1);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        sub = ts;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled) check("hold", {31'b0, out_valid, result}, {31'b0, 1'b1, held});
      if (out_valid && !out_ready) begin
        check("stall_in_ready", {63'b0, in_ready}, 64'd0);
        stalled = 1'b1;
        held = result;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", {63'b0, out_valid}, 64'd0);
        else check("stream_res", {32'b0, result}, {32'b0, q.pop_front()});
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ts ? ta - tb : ta + tb);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 64'(got), 64'(n));
    check("stream_left", 64'(q.size()), 64'd0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] r;
    logic [3:0]   f;   // {carry, overflow, zero, negative}
  } vec_t;

  vec_t vecs[8] = '{
    '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 4'b0000},
    '{32'h0000_0003, 32'h0000_0003, 1'b1, 32'h0000_0000, 4'b1010},
    '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 4'b0001},
    '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101},
    '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b1100},
    '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 4'b0000},
    '{32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFF, 4'b1000}
  };

  initial begin
    logic [W-1:0] r;
    logic [3:0]   f;
    int           lat;

    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b1;
`ifdef ADDSUB_SATURATE_EN
    sat_r     = 1'b0;
`endif
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_result", {32'b0, result}, 64'd0);
    check("rst_flags", {60'b0, carry_out, overflow, zero, negative}, 64'd0);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, r, f, lat);
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(S));
      check($sformatf("v%0d_res", i), {32'b0, r}, {32'b0, vecs[i].r});
      check($sformatf("v%0d_flags", i), {60'b0, f}, {60'b0, vecs[i].f});
    end

`ifdef ADDSUB_SATURATE_EN
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, r, f, lat);
    check("sat_pos_res", {32'b0, r}, {32'b0, 32'h7FFF_FFFF});
    check("sat_pos_flags", {60'b0, f}, {60'b0, 4'b0100});
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, r, f, lat);
    check("sat_neg_res", {32'b0, r}, {32'b0, 32'h8000_0000});
    check("sat_neg_flags", {60'b0, f}, {60'b0, 4'b1101});
    sat_r = 1'b0;
`endif

    stream(8, 1'b0);
    stream(200, 1'b1);

    // Three ops in flight, the first held at the output, then an asynchronous reset between edges.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = (i == 0) ? 32'hFFFF_FFFF : W'(i);
      b = 32'h0000_0001;
      sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", {63'b0, out_valid}, 64'd1);
    check("pre_rst_flags", {60'b0, carry_out, overflow, zero, negative}, {60'b0, 4'b1010});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'b0, out_valid}, 64'd0);
    check("async_rst_result", {32'b0, result}, 64'd0);
    check("async_rst_flags", {60'b0, carry_out, overflow, zero, negative}, 64'd0);
    check("async_rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, r, f, lat);
    check("post_rst_lat", 64'(lat), 64'(S));
    check("post_rst_res", {32'b0, r}, 64'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
